hilo_div_unit: RTL and testbench

- Iterative 32-cycle restoring divider for the DIV and DIVU instructions of the multicycle CPU.
- Sits directly upstream of the HI/LO write-back selectors.
- The quotient feeds LO and the remainder feeds HI through the existing mux2/mux4 data paths.
- The controller starts it with a one-cycle pulse and stalls on busy until done.

---
 rtl/hilo_div_unit.sv | 150 +++++++++++++++
 tb/tb_hilo_div_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, then a sign-fix cycle.
// Quotient goes to the LO path, remainder to the HI path.
module hilo_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              zero_q, zero_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic              dvd_neg, dvs_neg;
  logic [WIDTH-1:0]  dvd_mag, dvs_mag;
  logic [WIDTH:0]    rem_sh, trial;
  logic [WIDTH-1:0]  q_fix, r_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    q_d       = q_q;
    r_d       = r_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    dvd_neg = is_signed & dividend[WIDTH-1];
    dvs_neg = is_signed & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;

    // Remainder stays below the divisor, so WIDTH+1 bits hold the shifted value and trial sign.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};

    // Divide-by-zero leaves rem = |dividend|, so the normal sign fix restores the original bits.
    q_fix = zero_q ? {WIDTH{1'b1}} : (neg_quo_q ? (~quo_q + 1'b1) : quo_q);
    r_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          cnt_d     = CntW'(WIDTH);
          rem_d     = '0;
          quo_d     = dvd_mag;
          dvs_d     = dvs_mag;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          zero_d    = (divisor == '0);
          busy_d    = 1'b1;
        end
      end
      StRun: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        q_d     = q_fix;
        r_d     = r_fix;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = zero_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      q_q       <= q_d;
      r_q       <= r_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: driver pushes reference results, monitor checks on done.
module tb_hilo_div_unit;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        dbz;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  hilo_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .dbz      (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with truncating division.
  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb_;
    e.cyc = 0;
    if (b == 32'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (s) begin
      sa    = longint'($signed(a));
      sb_   = longint'($signed(b));
      e.q   = 32'(sa / sb_);
      e.r   = 32'(sa % sb_);
      e.dbz = 1'b0;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("q", q, mon_e.q);
        chk("r", r, mon_e.r);
        chk("dbz", {31'b0, dbz}, {31'b0, mon_e.dbz});
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("busy_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=%b expected 0 within 100 cycles", busy);
    end
  endtask

  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, output exp_t e);
    wait_idle();
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e     = model(s, a, b);
    e.cyc = cyc + 33;
    sb.push_back(e);
    // Operand changes after the sampling edge must not matter.
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected bench to finish");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [31:0] a, b;
    int          pick;

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dbz", {31'b0, dbz}, 32'd0);
    rst = 1'b0;

    // Basic DIVU with hold check.
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, e);
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("hold_q", q, 32'h0FFF_FFFF);
    chk("hold_r", r, 32'h0000_000F);
    chk("hold_done", {31'b0, done}, 32'd0);

    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, e);
    issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, e);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, e);
    issue(1'b1, 32'h1234_5678, 32'h0000_0000, e);
    issue(1'b0, 32'h1234_5678, 32'h0000_0000, e);
    issue(1'b1, 32'h8000_0000, 32'h0000_0000, e);
    issue(1'b0, 32'h0000_0064, 32'h0000_0003, e);

    // Start during busy is ignored; start in the done cycle is accepted.
    issue(1'b0, 32'd100, 32'd7, e);
    repeat (10) @(posedge clk);
    #1;
    is_signed = 1'b0;
    dividend  = 32'd50;
    divisor   = 32'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignored_start", {31'b0, busy}, 32'd1);
    wait_idle();
    chk("done_when_idle", {31'b0, done}, 32'd1);
    issue(1'b0, 32'd50, 32'd5, e);

    // Reset mid-operation discards it.
    issue(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, e);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_q", q, 32'd0);
    chk("midrst_r", r, 32'd0);
    chk("midrst_dbz", {31'b0, dbz}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_still_idle", {31'b0, busy}, 32'd0);
    issue(1'b0, 32'd1000, 32'd33, e);

    for (int i = 0; i < 40; i++) begin
      pick = int'($urandom_range(0, 9));
      a    = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case (pick)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      issue(1'($urandom_range(0, 1)), a, b, e);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
